// File: rtl/popcount_argmax_acc.sv
// Accumulates BEATS_PER_VEC partial popcounts per class and reports the argmax class/score.
// Optional threshold hit output enabled by defining ARGMAX_THRESHOLD_EN.
module popcount_argmax_acc #(
  parameter int IN_WIDTH      = 8,
  parameter int BEATS_PER_VEC = 4,
  parameter int NUM_CLASSES   = 10,
  parameter int SCORE_WIDTH   = IN_WIDTH + $clog2(BEATS_PER_VEC + 1),
  parameter int IDX_WIDTH     = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_WIDTH-1:0]    in_sum,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IDX_WIDTH-1:0]   out_idx,
  output logic [SCORE_WIDTH-1:0] out_score,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef ARGMAX_THRESHOLD_EN
  ,
  input  logic [SCORE_WIDTH-1:0] thresh,
  output logic                   out_hit
`endif
);

  localparam int BW = (BEATS_PER_VEC > 1) ? $clog2(BEATS_PER_VEC) : 1;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] acc_q, acc_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [IDX_WIDTH-1:0]   cls_cnt_q, cls_cnt_d;
  logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]   out_idx_q, out_idx_d;
  logic [SCORE_WIDTH-1:0] out_score_q, out_score_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_hit_q, out_hit_d;

  logic [SCORE_WIDTH-1:0] vec_score;
  logic [SCORE_WIDTH-1:0] cand_score;
  logic [IDX_WIDTH-1:0]   cand_idx;
  logic                   last_beat;
  logic                   take;

  always_comb begin
    vec_score  = acc_q + SCORE_WIDTH'(in_sum);
    last_beat  = (beat_cnt_q == BW'(BEATS_PER_VEC - 1));
    // First class always wins; afterwards only a strictly greater score replaces the best.
    take       = (cls_cnt_q == '0) || (vec_score > best_score_q);
    cand_score = take ? vec_score : best_score_q;
    cand_idx   = take ? cls_cnt_q : best_idx_q;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    cls_cnt_d    = cls_cnt_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    out_idx_d    = out_idx_q;
    out_score_d  = out_score_q;
    out_valid_d  = out_valid_q;
    out_hit_d    = out_hit_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (!last_beat) begin
            acc_d      = vec_score;
            beat_cnt_d = beat_cnt_q + BW'(1);
          end else begin
            acc_d        = '0;
            beat_cnt_d   = '0;
            best_score_d = cand_score;
            best_idx_d   = cand_idx;
            if (cls_cnt_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
              cls_cnt_d   = '0;
              out_idx_d   = cand_idx;
              out_score_d = cand_score;
              out_valid_d = 1'b1;
`ifdef ARGMAX_THRESHOLD_EN
              out_hit_d   = (cand_score >= thresh);
`else
              out_hit_d   = 1'b0;
`endif
              state_d     = ST_OUT;
            end else begin
              cls_cnt_d = cls_cnt_q + IDX_WIDTH'(1);
            end
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          best_score_d = '0;
          state_d      = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACC;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      cls_cnt_q    <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      out_idx_q    <= '0;
      out_score_q  <= '0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      cls_cnt_q    <= cls_cnt_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      out_idx_q    <= out_idx_d;
      out_score_q  <= out_score_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_score = out_score_q;
`ifdef ARGMAX_THRESHOLD_EN
  assign out_hit   = out_hit_q;
`else
  logic unused_hit;
  assign unused_hit = out_hit_q;
`endif

endmodule

// File: tb/tb_popcount_argmax_acc.sv
// Directed bench for popcount_argmax_acc (default parameters: 8-bit beats, 4 beats, 10 classes).
module tb_popcount_argmax_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_sum;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_idx;
  logic [10:0] out_score;
  logic        out_valid;
  logic        out_ready;
`ifdef ARGMAX_THRESHOLD_EN
  logic [10:0] thresh;
  logic        out_hit;
`endif

  int errors = 0;
  int checks = 0;
  int vec [0:39];
  int early_valid;

  popcount_argmax_acc dut (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_score(out_score), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ARGMAX_THRESHOLD_EN
    , .thresh(thresh), .out_hit(out_hit)
`endif
  );

  always #5 clk = ~clk;

  // Entered at a negedge; returns at the negedge following acceptance.
  task automatic send_beat(input int v);
    int n = 0;
    in_sum   = 8'(v);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int n, input bit gaps);
    early_valid = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      if (out_valid) early_valid++;
      send_beat(vec[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic fill(input int hi_cls, input int hi_val, input int lo_mul);
    for (int c = 0; c < 10; c++)
      for (int b = 0; b < 4; b++)
        vec[c*4+b] = (c == hi_cls) ? hi_val : c * lo_mul;
  endtask

  task automatic check_result(input string name, input int idx, input int score);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%0b required=1", name, out_valid); end
    checks++;
    if (out_idx !== 4'(idx)) begin errors++; $display("FAIL %s_idx got=%0d required=%0d", name, out_idx, idx); end
    checks++;
    if (out_score !== 11'(score)) begin errors++; $display("FAIL %s_score got=%0d required=%0d", name, out_score, score); end
    checks++;
    if (early_valid != 0) begin errors++; $display("FAIL %s_early_valid got=%0d required=0", name, early_valid); end
  endtask

  task automatic finish_handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%0b in_ready=%0b required=0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
`ifdef ARGMAX_THRESHOLD_EN
    thresh = 11'd300;
`endif
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_score !== 11'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid=%0b idx=%0d score=%0d in_ready=%0b required=0/0/0/1",
               out_valid, out_idx, out_score, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    fill(-1, 0, 5);
    out_ready = 1'b1;
    stream(40, 1'b0);
    check_result("ascending", 9, 180);
`ifdef ARGMAX_THRESHOLD_EN
    checks++;
    if (out_hit !== 1'b0) begin errors++; $display("FAIL ascending_hit got=%0b required=0", out_hit); end
`endif
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ascending_one_cycle got=%0b required=0", out_valid); end
  endtask

  task automatic test_tie();
    for (int c = 0; c < 10; c++)
      for (int b = 0; b < 4; b++)
        vec[c*4+b] = (c == 2 || c == 7) ? 50 : ((b < 2) ? 3 : 2);
    stream(40, 1'b0);
    check_result("tie", 2, 200);
    finish_handshake("tie");
  endtask

  task automatic test_max();
    for (int i = 0; i < 40; i++) vec[i] = 255;
    stream(40, 1'b0);
    check_result("max", 0, 1020);
    finish_handshake("max");
  endtask

  task automatic test_back_to_back();
    fill(-1, 0, 4);
    vec[12] = 40; vec[13] = 41; vec[14] = 42; vec[15] = 43;  // class 3 = 166
    out_ready = 1'b0;
    stream(40, 1'b0);
    check_result("bp", 3, 166);
    // Present the next inference's first beat while the result is held.
    fill(5, 70, 1);
    in_sum = 8'(vec[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 4'd3 || out_score !== 11'd166) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d in_ready=%0b valid=%0b idx=%0d score=%0d required=0/1/3/166",
                 i, in_ready, out_valid, out_idx, out_score);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_ready got=%0b required=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume in_ready=%0b valid=%0b required=1/0", in_ready, out_valid);
    end
    stream(40, 1'b0);
    check_result("bp_next", 5, 280);
    finish_handshake("bp_next");
  endtask

  task automatic test_gaps_reset();
    for (int i = 0; i < 40; i++) vec[i] = 200;
    stream(19, 1'b1);  // through class 4 beat 2
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_score !== 11'd0) begin
      errors++;
      $display("FAIL midreset valid=%0b idx=%0d score=%0d required=0/0/0", out_valid, out_idx, out_score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(6, 100, 3);
    stream(40, 1'b1);
    check_result("gaps", 6, 400);
    finish_handshake("gaps");
  endtask

`ifdef ARGMAX_THRESHOLD_EN
  task automatic test_threshold();
    fill(3, 80, 2);
    stream(40, 1'b0);
    check_result("thresh", 3, 320);
    checks++;
    if (out_hit !== 1'b1) begin errors++; $display("FAIL thresh_hit got=%0b required=1", out_hit); end
    finish_handshake("thresh");
  endtask
`endif

  initial begin
    test_reset();
    test_ascending();
    test_tie();
    test_max();
    test_back_to_back();
    test_gaps_reset();
`ifdef ARGMAX_THRESHOLD_EN
    test_threshold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
